mul_exec_unit: RTL and testbench

- Parametrised multi-cycle multiply execution unit for the MIPS execute stage.
- Replaces the fixed 16x16 multiplier that ran on its own PLL clock. It runs in the single CPU clock domain.
- Provides a start/ready/busy/done handshake so the pipeline can stall on it instead of scaling the system clock down.
- Adds signed mode, configurable bits-per-cycle throughput, and abort on pipeline flush.

---
 rtl/mul_exec_unit.sv | 120 ++++++++++++
 tb/tb_mul_exec_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_exec_unit.sv
// Multi-cycle shift-and-add multiply unit for the execute stage, with signed mode,
// configurable bits per iteration and a start/ready/busy/done handshake with flush abort.
module mul_exec_unit #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 sign_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mult_q, mult_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             resNeg_q, resNeg_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q, done_d;

  logic [PW-1:0]    partial;
  logic [WIDTH-1:0] magA, magB;

  // Operands are reduced to magnitudes; the most negative value maps onto itself,
  // which is its correct unsigned magnitude.
  assign magA = (sign_mode && op_a[WIDTH-1]) ? -op_a : op_a;
  assign magB = (sign_mode && op_b[WIDTH-1]) ? -op_b : op_b;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    cnt_d     = cnt_q;
    resNeg_d  = resNeg_q;
    product_d = product_q;
    done_d    = 1'b0;

    // The multiplicand is kept pre-shifted, so each slice's partial product
    // lands at the current shift position without a variable shifter.
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mult_q[i]) partial = partial + (mcand_q << i);
    end

    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          mcand_d  = {{WIDTH{1'b0}}, magA};
          mult_d   = magB;
          acc_d    = '0;
          cnt_d    = '0;
          resNeg_d = sign_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_q + partial;
          mcand_d = mcand_q << BITS_PER_CYCLE;
          mult_d  = mult_q >> BITS_PER_CYCLE;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!abort) begin
          product_d = resNeg_q ? -acc_q : acc_q;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      cnt_q     <= '0;
      resNeg_q  <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      cnt_q     <= cnt_d;
      resNeg_q  <= resNeg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == CALC) || (state_q == DONE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_exec_unit.sv
// Bench for mul_exec_unit: three instances (1, 2 and 4 bits per cycle) share one stimulus
// stream and are checked against an arithmetic reference product and latency model.
module tb_mul_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        sign_mode;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  readyV;
  logic [2:0]  busyV;
  logic [2:0]  doneV;
  logic [31:0] prodV [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_exec_unit #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sign_mode(sign_mode),
    .op_a(op_a), .op_b(op_b), .ready(readyV[0]), .busy(busyV[0]), .done(doneV[0]),
    .product(prodV[0])
  );
  mul_exec_unit #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sign_mode(sign_mode),
    .op_a(op_a), .op_b(op_b), .ready(readyV[1]), .busy(busyV[1]), .done(doneV[1]),
    .product(prodV[1])
  );
  mul_exec_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sign_mode(sign_mode),
    .op_a(op_a), .op_b(op_b), .ready(readyV[2]), .busy(busyV[2]), .done(doneV[2]),
    .product(prodV[2])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Instance i retires 2^i multiplier bits per cycle; done lands N+1 cycles after acceptance.
  function automatic int latOf(input int i);
    return 16 / (1 << i) + 1;
  endfunction

  function automatic logic [31:0] refProduct(input logic [15:0] a, input logic [15:0] b,
                                             input logic sgn);
    longint x, y;
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  // One operation on all three instances; optionally pokes start while they are busy.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                               input bit pokeBusy);
    logic [31:0] exp;
    int          doneCnt [3];
    int          doneAt [3];
    logic [31:0] got [3];
    exp = refProduct(a, b, sgn);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sign_mode = sgn;
    @(negedge clk);
    start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); sign_mode = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      checkOutput("busyAfterStart", 64'(busyV[i]), 64'(1));
      doneCnt[i] = 0; doneAt[i] = -1; got[i] = '0;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (doneV[i]) begin
          doneCnt[i]++; doneAt[i] = k; got[i] = prodV[i];
        end
        if (k == latOf(i) - 1) checkOutput("busyBeforeDone", 64'(busyV[i]), 64'(1));
        if (k == latOf(i))     checkOutput("readyAtDone", 64'(readyV[i]), 64'(1));
      end
      start = pokeBusy && (k == 2);
      if (pokeBusy && k == 2) begin
        op_a = 16'h0003; op_b = 16'h0003; sign_mode = 1'b0;
      end else begin
        op_a = 16'($urandom); op_b = 16'($urandom);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("doneCount", 64'(doneCnt[i]), 64'(1));
      checkOutput("doneCycle", 64'(doneAt[i]), 64'(latOf(i)));
      checkOutput("productAtDone", 64'(got[i]), 64'(exp));
      checkOutput("productHeld", 64'(prodV[i]), 64'(exp));
    end
  endtask

  task automatic abortTest();
    logic [31:0] prior [3];
    int          doneCnt [3];
    for (int i = 0; i < 3; i++) begin
      prior[i] = prodV[i]; doneCnt[i] = 0;
    end
    @(negedge clk);
    start = 1'b1; op_a = 16'd7; op_b = 16'd9; sign_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (doneV[i]) doneCnt[i]++;
      if (k == 6) checkOutput("abortStillBusy", 64'(readyV[0]), 64'(0));
      if (k == 7) begin
        checkOutput("abortReady1", 64'(readyV[0]), 64'(1));
        checkOutput("abortReady2", 64'(readyV[1]), 64'(1));
      end
      abort = (k == 6);
    end
    abort = 1'b0;
    checkOutput("abortNoDone1", 64'(doneCnt[0]), 64'(0));
    checkOutput("abortNoDone2", 64'(doneCnt[1]), 64'(0));
    checkOutput("abortKeep1", 64'(prodV[0]), 64'(prior[0]));
    checkOutput("abortKeep2", 64'(prodV[1]), 64'(prior[1]));
    checkOutput("abortLateDone4", 64'(doneCnt[2]), 64'(1));
    checkOutput("abortLateProd4", 64'(prodV[2]), 64'(63));
  endtask

  task automatic startAbortTest();
    logic [31:0] prior [3];
    int          doneCnt;
    doneCnt = 0;
    for (int i = 0; i < 3; i++) prior[i] = prodV[i];
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sign_mode = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("startAbortReady", 64'(readyV), 64'(3'b111));
    checkOutput("startAbortBusy", 64'(busyV), 64'(3'b000));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (doneV != 3'b000) doneCnt++;
    end
    checkOutput("startAbortNoDone", 64'(doneCnt), 64'(0));
    for (int i = 0; i < 3; i++) checkOutput("startAbortKeep", 64'(prodV[i]), 64'(prior[i]));
  endtask

  // Second request issued at the first edge the BPC=1 unit is ready again.
  task automatic backToBackTest();
    int doneCnt;
    bit stable;
    doneCnt = 0; stable = 1'b1;
    @(negedge clk);
    start = 1'b1; op_a = 16'd2; op_b = 16'd3; sign_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (doneV[0]) doneCnt++;
      if (k == 17) begin
        checkOutput("b2bFirstDone", 64'(doneV[0]), 64'(1));
        checkOutput("b2bFirstProd", 64'(prodV[0]), 64'(6));
      end
      if (k > 17 && k < 35 && (prodV[0] != 32'd6 || doneV[0])) stable = 1'b0;
      if (k == 35) begin
        checkOutput("b2bSecondDone", 64'(doneV[0]), 64'(1));
        checkOutput("b2bSecondProd", 64'(prodV[0]), 64'(20));
      end
      start = (k == 17);
      if (k == 17) begin
        op_a = 16'd4; op_b = 16'd5;
      end
    end
    start = 1'b0;
    checkOutput("b2bStable", 64'(stable), 64'(1));
    checkOutput("b2bDoneCount", 64'(doneCnt), 64'(2));
    for (int i = 0; i < 3; i++) checkOutput("b2bFinalProd", 64'(prodV[i]), 64'(20));
  endtask

  task automatic resetMidOpTest();
    @(negedge clk);
    start = 1'b1; op_a = 16'd100; op_b = 16'd100; sign_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstReady", 64'(readyV), 64'(3'b111));
    checkOutput("rstBusy", 64'(busyV), 64'(3'b000));
    checkOutput("rstDone", 64'(doneV), 64'(3'b000));
    for (int i = 0; i < 3; i++) checkOutput("rstProduct", 64'(prodV[i]), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(16'd100, 16'd100, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; sign_mode = 1'b0; op_a = '0; op_b = '0;
    #12;
    checkOutput("resetReady", 64'(readyV), 64'(3'b111));
    checkOutput("resetBusy", 64'(busyV), 64'(3'b000));
    checkOutput("resetDone", 64'(doneV), 64'(3'b000));
    checkOutput("resetProduct", 64'(prodV[0]), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(16'hFFFD, 16'h0005, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
    applyStimulus(16'd1234, 16'd5678, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0002, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'hFFFF, 1'b1, 1'b0);

    abortTest();
    startAbortTest();
    backToBackTest();
    resetMidOpTest();

    for (int n = 0; n < 15; n++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
